dma_copy: RTL and testbench



---
 rtl/dma_pkg.sv | 32 +++
 rtl/dma_regs.sv | 80 ++++++++
 rtl/dma_copy.sv | 134 +++++++++++++
 tb/tb_dma_copy.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the dma_copy word-copy engine.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    NEXT  = 2'd3
  } dma_state_e;

  localparam logic [3:0] REG_SRC   = 4'h0;
  localparam logic [3:0] REG_DST   = 4'h4;
  localparam logic [3:0] REG_COUNT = 4'h8;
  localparam logic [3:0] REG_CTRL  = 4'hC;

  // CTRL write bits (START, FILL) and STATUS read bits (BUSY, DONE)
  localparam int START = 0;
  localparam int FILL  = 1;
  localparam int BUSY  = 0;
  localparam int DONE  = 1;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] count;
  } dma_cfg_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dma_regs.sv
// Responder register file for dma_copy: SRC/DST/COUNT, start pulse, done flag, read mux.
// DMA_FILL_EN adds the fill-mode start bit and the fill pattern.
module dma_regs
  import dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        rw,
  input  logic [3:0]  address,
  input  logic [31:0] wdata,
  input  logic        busy,
  input  logic        done_set,
  output logic [31:0] rdata,
  output dma_cfg_t    cfg,
  output logic        start,
`ifdef DMA_FILL_EN
  output logic        start_fill,
  output logic [31:0] pattern,
`endif
  output logic        done
);

  logic [3:0] off;
  logic       wr;
  logic       addr_unused;

  assign off         = {address[3:2], 2'b00};
  assign addr_unused = ^address[1:0];
  assign wr          = enable & rw;
  assign start       = wr & (off == REG_CTRL) & wdata[START] & ~busy;

`ifdef DMA_FILL_EN
  assign start_fill = wdata[FILL];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg  <= '0;
      done <= 1'b0;
`ifdef DMA_FILL_EN
      pattern <= '0;
`endif
    end else begin
      if (wr && !busy) begin
        case (off)
          REG_SRC: begin
            cfg.src <= word_align(wdata);
`ifdef DMA_FILL_EN
            // the fill pattern keeps the full word, low bits included
            pattern <= wdata;
`endif
          end
          REG_DST:   cfg.dst   <= word_align(wdata);
          REG_COUNT: cfg.count <= wdata;
          default: ;
        endcase
      end
      // done_set wins over start so a COUNT==0 start lands as done
      if (start)    done <= 1'b0;
      if (done_set) done <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (enable) begin
      case (off)
        REG_SRC:   rdata = cfg.src;
        REG_DST:   rdata = cfg.dst;
        REG_COUNT: rdata = cfg.count;
        default: begin
          rdata[BUSY] = busy;
          rdata[DONE] = done;
        end
      endcase
    end
  end

endmodule

// File: rtl/dma_copy.sv
// Memory-to-memory word copy engine: register responder plus READ/WRITE/NEXT bus initiator.
// DMA_FILL_EN enables fill mode (constant pattern writes, no reads).
module dma_copy
  import dma_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_rw,
  input  logic [3:0]  i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ready
);

  dma_state_e  state_q, state_d;
  dma_cfg_t    cfg;
  logic        start, done, done_set, busy;
  logic [31:0] src_q, dst_q, cnt_q, hold_q;
  logic [31:0] wr_word;
  logic        fill_now, fill_act;

  assign busy    = (state_q != IDLE);
  assign o_ready = i_enable;

`ifdef DMA_FILL_EN
  logic        start_fill, fill_q;
  logic [31:0] pattern;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)    fill_q <= 1'b0;
    else if (start) fill_q <= start_fill;
  end

  assign fill_now = start_fill;
  assign fill_act = fill_q;
  assign wr_word  = fill_q ? pattern : hold_q;
`else
  assign fill_now = 1'b0;
  assign fill_act = 1'b0;
  assign wr_word  = hold_q;
`endif

  dma_regs u_regs (
    .clk        (i_clock),
    .rst        (i_reset),
    .enable     (i_enable),
    .rw         (i_rw),
    .address    (i_address),
    .wdata      (i_wdata),
    .busy       (busy),
    .done_set   (done_set),
    .rdata      (o_rdata),
    .cfg        (cfg),
    .start      (start),
`ifdef DMA_FILL_EN
    .start_fill (start_fill),
    .pattern    (pattern),
`endif
    .done       (done)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      src_q  <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
      hold_q <= '0;
    end else begin
      if (start) begin
        src_q <= cfg.src;
        dst_q <= cfg.dst;
        cnt_q <= cfg.count;
      end
      if (state_q == READ && i_bus_ready) hold_q <= i_bus_rdata;
      // addresses wrap modulo 2^32 by plain overflow
      if (state_q == NEXT) begin
        src_q <= src_q + 32'd4;
        dst_q <= dst_q + 32'd4;
        cnt_q <= cnt_q - 32'd1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    o_bus_request = 1'b0;
    o_bus_rw      = 1'b0;
    o_bus_address = '0;
    o_bus_wdata   = '0;
    done_set      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg.count == '0) done_set = 1'b1;
          else                 state_d  = fill_now ? WRITE : READ;
        end
      end
      READ: begin
        o_bus_request = 1'b1;
        o_bus_address = src_q;
        if (i_bus_ready) state_d = WRITE;
      end
      WRITE: begin
        o_bus_request = 1'b1;
        o_bus_rw      = 1'b1;
        o_bus_address = dst_q;
        o_bus_wdata   = wr_word;
        if (i_bus_ready) state_d = NEXT;
      end
      NEXT: begin
        if (cnt_q == 32'd1) begin
          done_set = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = fill_act ? WRITE : READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy: bus memory model with programmable wait states and a transaction log.
module tb_dma_copy;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, rw = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        breq, brw, bready;
  logic [31:0] baddr, bwdata, brdata;

  always #5 clk = ~clk;

  dma_copy dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_enable      (en),
    .i_rw          (rw),
    .i_address     (addr),
    .i_wdata       (wdata),
    .o_rdata       (rdata),
    .o_ready       (ready),
    .o_bus_request (breq),
    .o_bus_rw      (brw),
    .o_bus_address (baddr),
    .o_bus_wdata   (bwdata),
    .i_bus_rdata   (brdata),
    .i_bus_ready   (bready)
  );

  logic [31:0] mem [0:255];
  int          wait_cfg = 0;
  int          wcnt = 0;

  assign brdata = mem[baddr[9:2]];
  assign bready = breq && (wcnt >= wait_cfg);

  always @(posedge clk) wcnt <= (breq && !bready) ? wcnt + 1 : 0;

  logic [31:0] log_addr [0:63];
  logic [31:0] log_data [0:63];
  logic        log_rw   [0:63];
  int          n_log = 0, req_cyc = 0, hold_cyc = 0, hold_bad = 0;
  logic        pend = 1'b0, pend_rw = 1'b0;
  logic [31:0] pend_addr = '0, pend_wdata = '0;

  always @(negedge clk) begin
    if (breq) begin
      req_cyc <= req_cyc + 1;
      if (pend) begin
        hold_cyc <= hold_cyc + 1;
        if (baddr != pend_addr || brw != pend_rw || (brw && bwdata != pend_wdata))
          hold_bad <= hold_bad + 1;
      end
      if (bready && n_log < 64) begin
        log_addr[n_log] <= baddr;
        log_rw[n_log]   <= brw;
        log_data[n_log] <= brw ? bwdata : brdata;
        n_log           <= n_log + 1;
      end
      pend       <= !bready;
      pend_addr  <= baddr;
      pend_rw    <= brw;
      pend_wdata <= bwdata;
    end else begin
      pend <= 1'b0;
    end
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; rw = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    en = 1'b0; rw = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [31:0] d);
    en = 1'b1; rw = 1'b0; addr = a;
    #1;
    d  = rdata;
    en = 1'b0;
  endtask

  // counts rising edges from the caller's last edge until STATUS shows done
  task automatic wait_done(output int edges);
    logic [31:0] st;
    edges = 0;
    reg_read(4'hC, st);
    while (!st[1] && edges < 500) begin
      @(posedge clk);
      #1;
      edges++;
      reg_read(4'hC, st);
    end
    if (!st[1]) check("done_timeout", st, 32'h2);
  endtask

  task automatic check_log(input string tag, input int idx, input logic exp_rw,
                           input logic [31:0] exp_a, input logic [31:0] exp_d);
    check({tag, "_rw"},   {31'b0, log_rw[idx]}, {31'b0, exp_rw});
    check({tag, "_addr"}, log_addr[idx], exp_a);
    check({tag, "_data"}, log_data[idx], exp_d);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] exp_d [0:3];
    int          e, base, r0, h0, b0;
    logic        found;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]   = 32'h11111111;
    mem[1]   = 32'h22222222;
    mem[2]   = 32'h33333333;
    mem[3]   = 32'h44444444;
    mem[32]  = 32'hCAFE0001;
    mem[33]  = 32'hCAFE0002;
    mem[255] = 32'hF00DF00D;
    exp_d[0] = 32'h11111111;
    exp_d[1] = 32'h22222222;
    exp_d[2] = 32'h33333333;
    exp_d[3] = 32'h44444444;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'b0, breq}, 32'h0);
    check("rst_rw", {31'b0, brw}, 32'h0);
    check("rst_baddr", baddr, 32'h0);
    check("rst_bwdata", bwdata, 32'h0);
    check("rst_rdata_idle", rdata, 32'h0);
    reg_read(4'h0, v);  check("rst_src", v, 32'h0);
    reg_read(4'hC, v);  check("rst_status", v, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // copy, zero wait states
    reg_write(4'h0, 32'h00010003);
    reg_read(4'h0, v);  check("src_align", v, 32'h00010000);
    reg_write(4'h4, 32'h00010100);
    reg_write(4'h8, 32'd4);
    base = n_log;
    reg_write(4'hC, 32'h1);
    reg_read(4'hC, v);  check("busy_after_start", v, 32'h1);
    check("req_after_start", {31'b0, breq}, 32'h1);
    wait_done(e);
    check("copy_cycles", e, 32'd12);
    reg_read(4'hC, v);  check("copy_status", v, 32'h2);
    check("copy_ntx", n_log - base, 32'd8);
    for (int i = 0; i < 4; i++) begin
      check_log("copy_rd", base + 2*i,     1'b0, 32'h00010000 + 4*i, exp_d[i]);
      check_log("copy_wr", base + 2*i + 1, 1'b1, 32'h00010100 + 4*i, exp_d[i]);
    end

    // wait states: 3 low-ready cycles per transaction
    wait_cfg = 3;
    reg_write(4'h0, 32'h00010080);
    reg_write(4'h4, 32'h000100C0);
    reg_write(4'h8, 32'd2);
    base = n_log; h0 = hold_cyc; b0 = hold_bad;
    reg_write(4'hC, 32'h1);
    wait_done(e);
    check("wait_cycles", e, 32'd18);
    check("wait_ntx", n_log - base, 32'd4);
    check_log("wait_rd0", base,     1'b0, 32'h00010080, 32'hCAFE0001);
    check_log("wait_wr0", base + 1, 1'b1, 32'h000100C0, 32'hCAFE0001);
    check_log("wait_rd1", base + 2, 1'b0, 32'h00010084, 32'hCAFE0002);
    check_log("wait_wr1", base + 3, 1'b1, 32'h000100C4, 32'hCAFE0002);
    check("wait_hold_cycles", hold_cyc - h0, 32'd12);
    check("wait_hold_stable", hold_bad - b0, 32'd0);
    wait_cfg = 0;

    // COUNT == 0 start
    reg_write(4'h8, 32'd0);
    r0 = req_cyc;
    reg_write(4'hC, 32'h1);
    reg_read(4'hC, v);  check("zero_done", v, 32'h2);
    repeat (5) @(posedge clk);
    #1;
    check("zero_no_req", req_cyc - r0, 32'd0);

    // writes while busy are ignored
    reg_write(4'h0, 32'h00010000);
    reg_write(4'h4, 32'h00010180);
    reg_write(4'h8, 32'd3);
    base = n_log;
    reg_write(4'hC, 32'h1);
    repeat (2) @(posedge clk);
    reg_write(4'h8, 32'd99);
    reg_write(4'h0, 32'h00000040);
    reg_write(4'hC, 32'h1);
    wait_done(e);
    check("busy_cycles", e, 32'd4);
    check("busy_ntx", n_log - base, 32'd6);
    for (int i = 0; i < 3; i++) begin
      check_log("busy_rd", base + 2*i,     1'b0, 32'h00010000 + 4*i, exp_d[i]);
      check_log("busy_wr", base + 2*i + 1, 1'b1, 32'h00010180 + 4*i, exp_d[i]);
    end
    reg_read(4'h8, v);  check("busy_count_kept", v, 32'd3);
    reg_read(4'h0, v);  check("busy_src_kept", v, 32'h00010000);

    // address wrap at the top of the address space
    reg_write(4'h0, 32'hFFFFFFFC);
    reg_write(4'h4, 32'h00010200);
    reg_write(4'h8, 32'd2);
    base = n_log;
    reg_write(4'hC, 32'h1);
    wait_done(e);
    check("wrap_cycles", e, 32'd6);
    check_log("wrap_rd0", base,     1'b0, 32'hFFFFFFFC, 32'hF00DF00D);
    check_log("wrap_wr0", base + 1, 1'b1, 32'h00010200, 32'hF00DF00D);
    check_log("wrap_rd1", base + 2, 1'b0, 32'h00000000, 32'h11111111);
    check_log("wrap_wr1", base + 3, 1'b1, 32'h00010204, 32'h11111111);

`ifdef DMA_FILL_EN
    // fill mode: constant pattern, no reads
    reg_write(4'h0, 32'hDEADBEEF);
    reg_write(4'h4, 32'h00010000);
    reg_write(4'h8, 32'd3);
    base = n_log;
    reg_write(4'hC, 32'h3);
    wait_done(e);
    check("fill_cycles", e, 32'd6);
    reg_read(4'hC, v);  check("fill_status", v, 32'h2);
    check("fill_ntx", n_log - base, 32'd3);
    for (int i = 0; i < 3; i++)
      check_log("fill_wr", base + i, 1'b1, 32'h00010000 + 4*i, 32'hDEADBEEF);
`endif

    // reset during WRITE
    reg_write(4'h0, 32'h00010000);
    reg_write(4'h4, 32'h00010100);
    reg_write(4'h8, 32'd2);
    reg_write(4'hC, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (breq && brw) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("rstmid_saw_write", {31'b0, found}, 32'h1);
    rst = 1'b1;
    #1;
    check("rstmid_req_drop", {31'b0, breq}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    reg_read(4'hC, v);  check("rstmid_status", v, 32'h0);
    reg_read(4'h8, v);  check("rstmid_count", v, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rstmid_idle", {31'b0, breq}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
